// File: rtl/reg_file_nx_pkg.sv
// Shared constants for the RISC core register file: default geometry and the
// address-width helper used to size the port list.
package reg_file_nx_pkg;

  localparam int CORE_WIDTH = 16;
  localparam int CORE_DEPTH = 8;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_n_bit.sv
// WIDTH-bit storage register with load enable and synchronous clear (clear wins).
module reg_n_bit
  import reg_file_nx_pkg::*;
#(
  parameter int WIDTH = CORE_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/reg_file_nx.sv
// Datapath register file: DEPTH x WIDTH, one write port, two read ports, with
// optional hard-wired zero register, write bypass and registered read.
module reg_file_nx
  import reg_file_nx_pkg::*;
#(
  parameter int  WIDTH   = CORE_WIDTH,
  parameter int  DEPTH   = CORE_DEPTH,
  parameter bit  ZERO_R0 = 1'b1,
  parameter bit  BYPASS  = 1'b1,
  parameter bit  RD_REG  = 1'b0,
  localparam int ADDR_W  = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b
);

  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][WIDTH-1:0]   regs;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][WIDTH-1:0]  rdata;

  assign raddr   = {raddr_b, raddr_a};
  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

  // Storage bank: the write decode is folded into each slot's load enable.
  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (ZERO_R0 && i == 0) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_bank
      logic we;
      assign we = load && (waddr == ADDR_W'(i));
      reg_n_bit #(.WIDTH(WIDTH)) u_reg (
        .clk  (clk),
        .clr  (clr),
        .load (we),
        .d    (wdata),
        .q    (regs[i])
      );
    end
  end

  if (RD_REG) begin : g_rd_reg
    // Samples pre-write contents, so no bypass is needed or applied here.
    always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (clr) rdata[p] <= '0;
        else     rdata[p] <= regs[raddr[p]];
      end
    end
  end else begin : g_rd_comb
    logic wr_live;
    // A write to the zero register never lands, so it must never be forwarded.
    assign wr_live = load && !clr && !(ZERO_R0 && waddr == '0);

    always_comb begin
      rdata = '0;
      for (int p = 0; p < NUM_RD; p++) begin
        if (BYPASS && wr_live && raddr[p] == waddr) rdata[p] = wdata;
        else                                        rdata[p] = regs[raddr[p]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_nx.sv
// Directed bench for reg_file_nx: three configurations checked against a
// shadow model through a due-cycle scoreboard.
module tb_reg_file_nx;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  // 16x8 side: d0 = zero-reg + bypass, d1 = no zero-reg, no bypass
  logic        clr, load;
  logic [2:0]  waddr, raddr_a, raddr_b;
  logic [15:0] wdata, d0a, d0b, d1a, d1b;
  // 32x32 registered-read side
  logic        clr2, load2;
  logic [4:0]  waddr2, ra2, rb2;
  logic [31:0] wdata2, d2a, d2b;

  reg_file_nx #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1), .BYPASS(1'b1), .RD_REG(1'b0)) u_d0 (
    .clk(clk), .clr(clr), .load(load), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(d0a), .rdata_b(d0b));

  reg_file_nx #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b0), .BYPASS(1'b0), .RD_REG(1'b0)) u_d1 (
    .clk(clk), .clr(clr), .load(load), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(d1a), .rdata_b(d1b));

  reg_file_nx #(.WIDTH(32), .DEPTH(32), .ZERO_R0(1'b1), .BYPASS(1'b1), .RD_REG(1'b1)) u_d2 (
    .clk(clk), .clr(clr2), .load(load2), .waddr(waddr2), .wdata(wdata2),
    .raddr_a(ra2), .raddr_b(rb2), .rdata_a(d2a), .rdata_b(d2b));

  typedef struct {
    string       tag;
    int          src;
    int          due;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [15:0] m0[8];
  logic [15:0] m1[8];
  logic [31:0] m2[32];

  function automatic logic [31:0] obs(input int src);
    case (src)
      0:       return {16'h0, d0a};
      1:       return {16'h0, d0b};
      2:       return {16'h0, d1a};
      3:       return {16'h0, d1b};
      4:       return d2a;
      default: return d2b;
    endcase
  endfunction

  // Expected combinational read for the 16-bit configurations.
  function automatic logic [15:0] e16(input int d, input logic [2:0] a);
    if (d != 0) return m1[a];
    if (a == 3'd0) return 16'h0;
    if (load && !clr && a == waddr) return wdata;
    return m0[a];
  endfunction

  task automatic push(input string tag, input int src, input int due, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.src = src; e.due = due; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check();
    int i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        tests++;
        assert (obs(sb[i].src) === sb[i].exp) else begin
          fails++;
          $error("FAIL %s: observed %h expected %h", sb[i].tag, obs(sb[i].src), sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic update();
    if (clr) begin
      for (int k = 0; k < 8; k++) begin m0[k] = '0; m1[k] = '0; end
    end else if (load) begin
      if (waddr != 3'd0) m0[waddr] = wdata;
      m1[waddr] = wdata;
    end
    if (clr2) begin
      for (int k = 0; k < 32; k++) m2[k] = '0;
    end else if (load2 && waddr2 != 5'd0) begin
      m2[waddr2] = wdata2;
    end
  endtask

  task automatic tick();
    #3 check();
    update();
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic drive16(input logic c, input logic l, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [2:0] a, input logic [2:0] b,
                         input string tag);
    clr = c; load = l; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;
    clr2 = 1'b0; load2 = 1'b0;
    push({tag, "/d0a"}, 0, cyc, {16'h0, e16(0, a)});
    push({tag, "/d0b"}, 1, cyc, {16'h0, e16(0, b)});
    push({tag, "/d1a"}, 2, cyc, {16'h0, e16(1, a)});
    push({tag, "/d1b"}, 3, cyc, {16'h0, e16(1, b)});
  endtask

  task automatic s16(input logic c, input logic l, input logic [2:0] wa,
                     input logic [15:0] wd, input logic [2:0] a, input logic [2:0] b,
                     input string tag);
    drive16(c, l, wa, wd, a, b, tag);
    tick();
  endtask

  // Registered reads: result due on the cycle after the address is presented.
  task automatic s32(input logic c, input logic l, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b,
                     input string tag);
    clr = 1'b0; load = 1'b0;
    clr2 = c; load2 = l; waddr2 = wa; wdata2 = wd; ra2 = a; rb2 = b;
    push({tag, "/d2a"}, 4, cyc + 1, c ? 32'h0 : m2[a]);
    push({tag, "/d2b"}, 5, cyc + 1, c ? 32'h0 : m2[b]);
    tick();
  endtask

  initial begin
    logic [15:0] v;
    clr = 1'b1; load = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    clr2 = 1'b1; load2 = 1'b0; waddr2 = '0; wdata2 = '0; ra2 = 5'd31; rb2 = 5'd0;
    push("rst/d2a", 4, 1, 32'h0);
    push("rst/d2b", 5, 1, 32'h0);
    tick();

    for (int a = 0; a < 8; a++) s16(1'b0, 1'b0, 3'd0, 16'h0, 3'(a), 3'(7 - a), "rst_rd");

    for (int i = 1; i < 8; i++) begin
      v = 16'(32'h1111 * i);
      s16(1'b0, 1'b1, 3'(i), v, 3'(i), 3'(i - 1), "wr");
    end
    for (int i = 0; i < 8; i++) s16(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), "rd");

    s16(1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, "wr0");
    s16(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, "rd0");

    s16(1'b0, 1'b1, 3'd3, 16'h00AA, 3'd1, 3'd2, "wr3");
    drive16(1'b0, 1'b1, 3'd3, 16'h5555, 3'd3, 3'd3, "byp");
    push("byp_const", 0, cyc, 32'h5555);
    push("nobyp_const", 2, cyc, 32'h00AA);
    tick();
    push("after_const", 2, cyc, 32'h5555);
    s16(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3, "after");

    s16(1'b1, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, "clrwr");
    push("clrwr_const", 0, cyc, 32'h0);
    for (int a = 0; a < 8; a++) s16(1'b0, 1'b0, 3'd0, 16'h0, 3'(a), 3'(a), "clr_rd");

    for (int i = 0; i < 8; i++) begin
      v = 16'(32'h1357 * (i + 1));
      s16(1'b0, 1'b1, 3'(i), v, 3'(i), 3'(7 - i), "rewr");
    end
    for (int k = 0; k < 16; k++) begin
      v = k[0] ? 16'hFFFF : 16'h0000;
      s16(1'b0, 1'b0, 3'(k), v, 3'(k), 3'(k + 3), "hold");
    end

    s32(1'b0, 1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 5'd0, "w31");
    push("w31_old", 4, cyc, 32'h0);
    s32(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31, "r31");
    push("r31_new", 4, cyc, 32'hDEADBEEF);
    s32(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd31, "w0");
    s32(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31, "r0");
    s32(1'b1, 1'b1, 5'd31, 32'h1, 5'd31, 5'd31, "clr32");
    s32(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0, "post");

    #3 check();
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
